// File: rtl/iob2axi_burst.sv
// AXI4 master burst engine: moves LENGTH beats between a valid/ready stream and AXI4 memory,
// splitting the transfer into INCR bursts capped at MAX_BURST beats and at 4 KB page edges.
module iob2axi_burst #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 16,
  parameter int MAX_BURST = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                dir_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [LEN_W-1:0]    length_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                error_o,
  input  logic                s_wvalid_i,
  input  logic [DATA_W-1:0]   s_wdata_i,
  input  logic [DATA_W/8-1:0] s_wstrb_i,
  output logic                s_wready_o,
  output logic                s_rvalid_o,
  output logic [DATA_W-1:0]   s_rdata_o,
  input  logic                s_rready_i,
  output logic [ADDR_W-1:0]   m_axi_awaddr_o,
  output logic [7:0]          m_axi_awlen_o,
  output logic [2:0]          m_axi_awsize_o,
  output logic [1:0]          m_axi_awburst_o,
  output logic                m_axi_awvalid_o,
  input  logic                m_axi_awready_i,
  output logic [DATA_W-1:0]   m_axi_wdata_o,
  output logic [DATA_W/8-1:0] m_axi_wstrb_o,
  output logic                m_axi_wlast_o,
  output logic                m_axi_wvalid_o,
  input  logic                m_axi_wready_i,
  input  logic [1:0]          m_axi_bresp_i,
  input  logic                m_axi_bvalid_i,
  output logic                m_axi_bready_o,
  output logic [ADDR_W-1:0]   m_axi_araddr_o,
  output logic [7:0]          m_axi_arlen_o,
  output logic [2:0]          m_axi_arsize_o,
  output logic [1:0]          m_axi_arburst_o,
  output logic                m_axi_arvalid_o,
  input  logic                m_axi_arready_i,
  input  logic [DATA_W-1:0]   m_axi_rdata_i,
  input  logic [1:0]          m_axi_rresp_i,
  input  logic                m_axi_rlast_i,
  input  logic                m_axi_rvalid_i,
  output logic                m_axi_rready_o
);

  localparam int SIZE   = $clog2(DATA_W / 8);
  localparam int BCNT_W = $clog2(MAX_BURST) + 1;
  localparam int CMP_W  = (LEN_W > 13) ? LEN_W : 13;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, NEXT, DONE} state_t;

  state_t              state_q;
  logic                dir_q;
  logic                busy_q;
  logic                done_q;
  logic                error_q;
  logic                awvalid_q;
  logic                arvalid_q;
  logic                bready_q;
  logic [ADDR_W-1:0]   curAddr_q;
  logic [LEN_W-1:0]    remaining_q;
  logic [BCNT_W-1:0]   beats_q;
  logic [BCNT_W-1:0]   beatCnt_q;
  logic [BCNT_W-1:0]   beats_d;
  logic                wrData;
  logic                rdData;
  logic                lastBeat;
  logic                beatFire;

  // Burst length is the smallest of what is left, the burst cap, and the beats to the 4 KB edge.
  function automatic logic [BCNT_W-1:0] calcBeats(input logic [11:0] aLow,
                                                  input logic [LEN_W-1:0] rem);
    logic [12:0]      pageBeats;
    logic [CMP_W-1:0] n;
    pageBeats = (13'h1000 - {1'b0, aLow}) >> SIZE;
    n = CMP_W'(rem);
    if (CMP_W'(pageBeats) < n) n = CMP_W'(pageBeats);
    if (CMP_W'(MAX_BURST) < n) n = CMP_W'(MAX_BURST);
    return BCNT_W'(n);
  endfunction

  assign beats_d = (state_q == IDLE) ? calcBeats(addr_i[11:0], length_i)
                                     : calcBeats(curAddr_q[11:0], remaining_q);

  assign wrData   = (state_q == DATA) && dir_q;
  assign rdData   = (state_q == DATA) && !dir_q;
  assign lastBeat = (beatCnt_q == beats_q - BCNT_W'(1));

  assign m_axi_wvalid_o = wrData && s_wvalid_i;
  assign s_wready_o     = wrData && m_axi_wready_i;
  assign m_axi_wdata_o  = s_wdata_i;
  assign m_axi_wstrb_o  = s_wstrb_i;
  assign m_axi_wlast_o  = wrData && lastBeat;
  assign s_rvalid_o     = rdData && m_axi_rvalid_i;
  assign m_axi_rready_o = rdData && s_rready_i;
  assign s_rdata_o      = m_axi_rdata_i;
  assign beatFire       = (m_axi_wvalid_o && s_wready_o) || (s_rvalid_o && m_axi_rready_o);

  assign m_axi_awaddr_o  = curAddr_q;
  assign m_axi_awlen_o   = 8'(beats_q - BCNT_W'(1));
  assign m_axi_awsize_o  = 3'(SIZE);
  assign m_axi_awburst_o = 2'b01;
  assign m_axi_awvalid_o = awvalid_q;
  assign m_axi_araddr_o  = curAddr_q;
  assign m_axi_arlen_o   = 8'(beats_q - BCNT_W'(1));
  assign m_axi_arsize_o  = 3'(SIZE);
  assign m_axi_arburst_o = 2'b01;
  assign m_axi_arvalid_o = arvalid_q;
  assign m_axi_bready_o  = bready_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign error_o         = error_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      dir_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      awvalid_q   <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      curAddr_q   <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
      beatCnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            dir_q       <= dir_i;
            curAddr_q   <= addr_i;
            remaining_q <= length_i;
            error_q     <= 1'b0;
            busy_q      <= 1'b1;
            if (length_i == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= ADDR;
              beats_q   <= beats_d;
              awvalid_q <= dir_i;
              arvalid_q <= !dir_i;
            end
          end
        end
        ADDR: begin
          if ((awvalid_q && m_axi_awready_i) || (arvalid_q && m_axi_arready_i)) begin
            awvalid_q <= 1'b0;
            arvalid_q <= 1'b0;
            beatCnt_q <= '0;
            state_q   <= DATA;
          end
        end
        // The burst ends on the beat count; a misplaced or missing rlast only flags an error.
        DATA: begin
          if (beatFire) begin
            if (!dir_q && ((m_axi_rlast_i != lastBeat) || (m_axi_rresp_i != 2'b00)))
              error_q <= 1'b1;
            if (lastBeat) begin
              curAddr_q   <= curAddr_q + (ADDR_W'(beats_q) << SIZE);
              remaining_q <= remaining_q - LEN_W'(beats_q);
              if (dir_q) begin
                state_q  <= RESP;
                bready_q <= 1'b1;
              end else begin
                state_q <= NEXT;
              end
            end else begin
              beatCnt_q <= beatCnt_q + BCNT_W'(1);
            end
          end
        end
        RESP: begin
          if (m_axi_bvalid_i) begin
            bready_q <= 1'b0;
            if (m_axi_bresp_i != 2'b00) error_q <= 1'b1;
            state_q <= NEXT;
          end
        end
        NEXT: begin
          if (remaining_q != '0) begin
            state_q   <= ADDR;
            beats_q   <= beats_d;
            awvalid_q <= dir_q;
            arvalid_q <= !dir_q;
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
